// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus: registered one-hot grant,
// bounded tenure under contention and a fixed turnaround gap between owners.
module bus_arbiter_rr #(
    parameter  int NUM_DEVICES = 8,
    parameter  int C_WIDTH     = 8,
    parameter  int MAX_TENURE  = 16,
    parameter  int TURNAROUND  = 1,
    localparam int ID_W        = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
    localparam int TEN_W       = $clog2(MAX_TENURE),
    localparam int GAP_W       = $clog2(TURNAROUND + 1)
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [NUM_DEVICES-1:0]         req,
    input  logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in,
    output logic [NUM_DEVICES-1:0]         ack,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy,
    output logic [C_WIDTH-1:0]             ctrl_out,
    output logic                           timeout
);

    // state | meaning
    // IDLE  | no owner, arbitrate on every edge
    // GRANT | ack held by grant_id, tenure counter running
    // GAP   | turnaround, ack low, arbitrate on the last gap edge
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam int                SUM_W     = ID_W + 1;
    localparam logic [SUM_W-1:0]  NUM_DEV_W = SUM_W'(NUM_DEVICES);
    localparam logic [TEN_W-1:0]  TEN_LAST  = TEN_W'(MAX_TENURE - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TURNAROUND - 1);
    localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_DEVICES - 1);

    state_t                 state_q, state_d;
    logic [NUM_DEVICES-1:0] ack_d;
    logic [ID_W-1:0]        grant_id_d;
    logic [ID_W-1:0]        last_id_q, last_id_d;
    logic [TEN_W-1:0]       ten_cnt_q, ten_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   timeout_d;

    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic [SUM_W-1:0]       scan_sum;
    logic [ID_W-1:0]        scan_idx;
    logic                   others_req;
    logic                   arb_now;

    logic [C_WIDTH-1:0]     ctrl_arr [NUM_DEVICES];

    for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_ctrl
        assign ctrl_arr[g] = ctrl_in[g*C_WIDTH +: C_WIDTH];
    end

    assign busy       = |ack;
    assign ctrl_out   = busy ? ctrl_arr[grant_id] : '0;
    assign others_req = |(req & ~ack);

    // Scan starts one past the previous winner so the last owner ranks lowest.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NUM_DEVICES; i++) begin
            scan_sum = {1'b0, last_id_q} + SUM_W'(i);
            if (scan_sum >= NUM_DEV_W) begin
                scan_sum = scan_sum - NUM_DEV_W;
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = ack;
        grant_id_d = grant_id;
        last_id_d  = last_id_q;
        ten_cnt_d  = ten_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout_d  = 1'b0;
        arb_now    = 1'b0;

        case (state_q)
            IDLE: begin
                arb_now = 1'b1;
            end
            GRANT: begin
                if (!req[grant_id]) begin
                    ack_d     = '0;
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    ten_cnt_d = '0;
                end else if (ten_cnt_q == TEN_LAST) begin
                    // Saturated owner keeps the bus until someone else asks.
                    if (others_req) begin
                        ack_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = GAP;
                        gap_cnt_d = '0;
                        ten_cnt_d = '0;
                    end
                end else begin
                    ten_cnt_d = ten_cnt_q + TEN_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    arb_now = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (arb_now) begin
            if (win_found) begin
                state_d    = GRANT;
                ack_d      = NUM_DEVICES'(1) << win_id;
                grant_id_d = win_id;
                last_id_d  = win_id;
                ten_cnt_d  = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            ack       <= '0;
            grant_id  <= '0;
            last_id_q <= LAST_RST;
            ten_cnt_q <= '0;
            gap_cnt_q <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack       <= ack_d;
            grant_id  <= grant_id_d;
            last_id_q <= last_id_d;
            ten_cnt_q <= ten_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed vector table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_bus_arbiter_rr;

    localparam int N          = 8;
    localparam int CW         = 8;
    localparam int MT         = 16;
    localparam int TA         = 1;
    localparam int IW         = $clog2(N);
    localparam int WAIT_BOUND = (N - 1) * (MT + TA) + 1;

    logic            clk = 1'b0;
    logic            reset_L;
    logic [N-1:0]    req;
    logic [N*CW-1:0] ctrl_in;
    logic [N-1:0]    ack;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic [CW-1:0]   ctrl_out;
    logic            timeout;

    int vectors     = 0;
    int miscompares = 0;

    bus_arbiter_rr #(
        .NUM_DEVICES(N), .C_WIDTH(CW), .MAX_TENURE(MT), .TURNAROUND(TA)
    ) dut (
        .clk(clk), .reset_L(reset_L), .req(req), .ctrl_in(ctrl_in),
        .ack(ack), .grant_id(grant_id), .busy(busy), .ctrl_out(ctrl_out),
        .timeout(timeout)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] ack;
        logic         to;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int idx);
        logic [N-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        return N'(1) << idx;
    endfunction

    function automatic int id_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (bit_of(v, k)) return k;
        return -1;
    endfunction

    function automatic logic [CW-1:0] ctrl_of(input int idx);
        logic [N*CW-1:0] sh;
        sh = ctrl_in >> (idx * CW);
        return sh[CW-1:0];
    endfunction

    // Round-robin rule: first requester after the previous winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (bit_of(r, (last + k) % N)) return (last + k) % N;
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        reset_L = 1'b0;
        #5;
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_ctrl_out", 32'(ctrl_out), 32'(0));
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    function automatic void add(input logic [N-1:0] r, input logic [N-1:0] a, input logic t);
        vec_t v;
        v.req = r; v.ack = a; v.to = t;
        tbl.push_back(v);
    endfunction

    int m_owner, m_last, m_held, m_gap;
    logic m_to;

    task automatic model_step(input logic [N-1:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!bit_of(r, m_owner)) begin
                m_owner = -1;
                m_gap   = TA;
            end else if (m_held >= MT && (r & ~onehot(m_owner)) != '0) begin
                m_owner = -1;
                m_gap   = TA;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            if (r != '0) begin
                m_owner = rr_pick(r, m_last);
                m_last  = m_owner;
                m_held  = 1;
            end
        end
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] prev_ack;
        logic         held_ok, had_owner;
        int           hi_cnt, zero_run, id;
        int           wait_cnt [N];

        reset_L = 1'b0;
        req     = '0;
        ctrl_in = 64'hA7A6_A5A4_A3A2_A1A0;

        // Single owner release, then alternating 0/6 with one-cycle gaps.
        add(8'h80, 8'h80, 0); add(8'h80, 8'h80, 0); add(8'h80, 8'h80, 0);
        add(8'h80, 8'h80, 0); add(8'h80, 8'h80, 0); add(8'h00, 8'h00, 0);
        add(8'h00, 8'h00, 0); add(8'h00, 8'h00, 0);
        add(8'h41, 8'h01, 0); add(8'h41, 8'h01, 0); add(8'h41, 8'h01, 0);
        add(8'h40, 8'h00, 0); add(8'h41, 8'h40, 0); add(8'h41, 8'h40, 0);
        add(8'h41, 8'h40, 0); add(8'h01, 8'h00, 0); add(8'h41, 8'h01, 0);
        add(8'h41, 8'h01, 0); add(8'h41, 8'h01, 0); add(8'h40, 8'h00, 0);
        add(8'h41, 8'h40, 0); add(8'h00, 8'h00, 0); add(8'h00, 8'h00, 0);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].req);
            check($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ack != '0));
            check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
            id = id_of(tbl[i].ack);
            if (id >= 0) begin
                check($sformatf("tbl%0d_grant_id", i), 32'(grant_id), 32'(id));
                check($sformatf("tbl%0d_ctrl", i), 32'(ctrl_out), 32'(ctrl_of(id)));
            end else begin
                check($sformatf("tbl%0d_ctrl", i), 32'(ctrl_out), 32'(0));
            end
        end

        // CPU hogs the bus, UART joins on cycle 2: exactly MT cycles then revoke.
        do_reset();
        hi_cnt = 0;
        for (int c = 0; c < 3 * MT; c++) begin
            step((c >= 2) ? 8'hC0 : 8'h80);
            if (ack === 8'h80 && timeout === 1'b0) hi_cnt++;
            else break;
        end
        check("hog_tenure", 32'(hi_cnt), 32'(MT));
        check("hog_revoke_ack", 32'(ack), 32'(0));
        check("hog_timeout", 32'(timeout), 32'(1));
        step(8'hC0);
        check("hog_next_ack", 32'(ack), 32'(8'h40));
        check("hog_timeout_pulse", 32'(timeout), 32'(0));

        // Lone requester saturates quietly; contention then revokes at once.
        do_reset();
        held_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step(8'h08);
            if (ack !== 8'h08 || timeout !== 1'b0) held_ok = 1'b0;
        end
        check("sat_held", 32'(held_ok), 32'(1));
        step(8'h18);
        check("sat_revoke_ack", 32'(ack), 32'(0));
        check("sat_timeout", 32'(timeout), 32'(1));
        step(8'h18);
        check("sat_next_ack", 32'(ack), 32'(8'h10));
        check("sat_timeout_pulse", 32'(timeout), 32'(0));

        // Reset mid-grant between edges.
        do_reset();
        step(8'h10);
        check("mid_grant_ack", 32'(ack), 32'(8'h10));
        step(8'h10);
        #10;
        reset_L = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_ctrl", 32'(ctrl_out), 32'(0));
        @(posedge clk);
        #6;
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ack", 32'(ack), 32'(8'h10));
        check("mid_rel_grant_id", 32'(grant_id), 32'(4));

        // Randomized traffic against the reference model.
        do_reset();
        m_owner = -1; m_last = N - 1; m_held = 0; m_gap = 0; m_to = 1'b0;
        prev_ack  = '0;
        had_owner = 1'b0;
        zero_run  = 0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        r = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (bit_of(ack, k))      r[k] = ($urandom_range(0, 5) != 0);
                else if (bit_of(r, k))   r[k] = 1'b1;
                else                     r[k] = ($urandom_range(0, 9) == 0);
            end
            ctrl_in = {$urandom(), $urandom()};
            step(r);
            model_step(r);

            check("rand_ack", 32'(ack), 32'((m_owner >= 0) ? onehot(m_owner) : '0));
            check("rand_busy", 32'(busy), 32'(m_owner >= 0));
            check("rand_timeout", 32'(timeout), 32'(m_to));
            if (m_owner >= 0) begin
                check("rand_grant_id", 32'(grant_id), 32'(m_owner));
                check("rand_ctrl", 32'(ctrl_out), 32'(ctrl_of(m_owner)));
            end else begin
                check("rand_ctrl", 32'(ctrl_out), 32'(0));
            end
            check("rand_onehot", 32'($countones(ack) <= 1), 32'(1));

            if (ack != '0) begin
                check("rand_ack_req", 32'((ack & ~r) == '0), 32'(1));
                if (ack != prev_ack) begin
                    if (had_owner) check("rand_gap", 32'(zero_run >= TA), 32'(1));
                    had_owner = 1'b1;
                end
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_ack = ack;

            for (int k = 0; k < N; k++) begin
                if (bit_of(ack, k)) begin
                    if (wait_cnt[k] > 0)
                        check("rand_wait", 32'(wait_cnt[k] <= WAIT_BOUND), 32'(1));
                    wait_cnt[k] = 0;
                end else if (bit_of(r, k)) begin
                    wait_cnt[k]++;
                end else begin
                    wait_cnt[k] = 0;
                end
            end
        end
        for (int k = 0; k < N; k++)
            check("rand_wait_end", 32'(wait_cnt[k] <= WAIT_BOUND), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
